// File: rtl/complex_proc_controller.sv
// Sequencer for the 32x16 complex-number memory: runs a stored program from
// address 0, fetching two operands per instruction and writing back the result.
module complex_proc_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mem_rdata,
  output logic        mem_readwriteN,
  output logic [4:0]  mem_address,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [4:0]  pc
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD_A,
    LOAD_B,
    EXEC,
    WRITE,
    HALT
  } state_t;

  state_t      state;
  logic [15:0] ir;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] res;
  logic [15:0] alu_out;

  logic signed [7:0]  ar, ai, br, bi;
  logic signed [15:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [16:0] mul_re, mul_im;
  logic [7:0]         lane_re, lane_im;

  assign ar = opa[15:8];
  assign ai = opa[7:0];
  assign br = opb[15:8];
  assign bi = opb[7:0];

  // Each lane wraps to 8 bits; the product sums are kept at 17 bits before truncation.
  always_comb begin
    p_rr    = 16'(ar) * 16'(br);
    p_ii    = 16'(ai) * 16'(bi);
    p_ri    = 16'(ar) * 16'(bi);
    p_ir    = 16'(ai) * 16'(br);
    mul_re  = 17'(p_rr) - 17'(p_ii);
    mul_im  = 17'(p_ri) + 17'(p_ir);
    lane_re = 8'h00;
    lane_im = 8'h00;
    case (ir[15:14])
      2'b00: begin
        lane_re = ar + br;
        lane_im = ai + bi;
      end
      2'b01: begin
        lane_re = ar - br;
        lane_im = ai - bi;
      end
      default: begin
        lane_re = mul_re[7:0];
        lane_im = mul_im[7:0];
      end
    endcase
    alu_out = {lane_re, lane_im};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= 5'd0;
      ir    <= 16'h0000;
      opa   <= 16'h0000;
      opb   <= 16'h0000;
      res   <= 16'h0000;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc    <= 5'd0;
            state <= FETCH;
          end
        end
        FETCH: begin
          ir    <= mem_rdata;
          state <= (mem_rdata[15:14] == 2'b11) ? HALT : LOAD_A;
        end
        LOAD_A: begin
          opa   <= mem_rdata;
          state <= LOAD_B;
        end
        LOAD_B: begin
          opb   <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          res   <= alu_out;
          state <= WRITE;
        end
        WRITE: begin
          pc    <= pc + 5'd1;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port decodes from registers only, so nothing from mem_rdata or start leaks through.
  always_comb begin
    mem_readwriteN = 1'b1;
    mem_address    = 5'd0;
    case (state)
      FETCH:        mem_address = pc;
      LOAD_A:       mem_address = {ir[13], ir[12:9]};
      LOAD_B, EXEC: mem_address = {ir[13], ir[8:5]};
      WRITE: begin
        mem_address    = ir[4:0];
        mem_readwriteN = 1'b0;
      end
      default:      mem_address = 5'd0;
    endcase
  end

  assign mem_wdata = res;
  assign busy      = (state == FETCH) || (state == LOAD_A) || (state == LOAD_B) ||
                     (state == EXEC)  || (state == WRITE);
  assign done      = (state == HALT);

endmodule

// File: tb/tb_complex_proc_controller.sv
// Bench for complex_proc_controller: falling-edge memory model, an instruction-level
// interpreter as reference, and a per-cycle compare process.
module tb_complex_proc_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_readwriteN;
  logic [4:0]  mem_address;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [4:0]  pc;

  int vectors = 0;
  int miscompares = 0;

  complex_proc_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mem_readwriteN (mem_readwriteN),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  // Memory: reads and writes on the falling edge.
  logic [15:0] ram [32];
  always @(negedge clk) begin
    if (!mem_readwriteN) ram[mem_address] <= mem_wdata;
    else                 mem_rdata <= ram[mem_address];
  end

  // Reference: interprets the program one instruction at a time.
  logic [15:0] model_mem [32];
  logic [15:0] exp_ir [$];
  logic [4:0]  exp_wa [$];
  logic [15:0] exp_wd [$];
  int n_instr;
  int d_cycles;
  bit halts;

  function automatic logic [15:0] cplx(input logic [1:0] op, input logic [15:0] a,
                                       input logic [15:0] b);
    int ar, ai, br, bi, re, im;
    ar = int'($signed(a[15:8]));
    ai = int'($signed(a[7:0]));
    br = int'($signed(b[15:8]));
    bi = int'($signed(b[7:0]));
    case (op)
      2'b00:   begin re = ar + br; im = ai + bi; end
      2'b01:   begin re = ar - br; im = ai - bi; end
      default: begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
    endcase
    return {re[7:0], im[7:0]};
  endfunction

  task automatic model_run(input int cap);
    logic [4:0]  p;
    logic [15:0] w, r;
    for (int a = 0; a < 32; a++) model_mem[a] = ram[a];
    exp_ir.delete();
    exp_wa.delete();
    exp_wd.delete();
    p = 5'd0;
    halts = 1'b0;
    n_instr = 0;
    while (n_instr < cap) begin
      w = model_mem[p];
      if (w[15:14] == 2'b11) begin
        halts = 1'b1;
        break;
      end
      r = cplx(w[15:14], model_mem[{w[13], w[12:9]}], model_mem[{w[13], w[8:5]}]);
      model_mem[w[4:0]] = r;
      exp_ir.push_back(w);
      exp_wa.push_back(w[4:0]);
      exp_wd.push_back(r);
      p = p + 5'd1;
      n_instr++;
    end
    d_cycles = 5 * n_instr + 1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // k counts rising edges since the edge that sampled start (that edge is k=0).
  bit active = 1'b0;
  int k = -1;
  int first_done = -1;
  always @(posedge clk) begin
    #1;
    if (!active) begin
      k = -1;
      first_done = -1;
    end else begin
      int i, ph;
      logic [15:0] w;
      k++;
      if (done && first_done < 0) first_done = k;
      if (halts && k >= d_cycles) begin
        checkOutput("halt_busy", busy, 0);
        checkOutput("halt_done", done, 1);
        checkOutput("halt_rw", mem_readwriteN, 1);
        checkOutput("halt_pc", pc, n_instr % 32);
      end else begin
        i  = k / 5;
        ph = k % 5;
        checkOutput("run_busy", busy, 1);
        checkOutput("run_done", done, 0);
        checkOutput("run_pc", pc, i % 32);
        checkOutput("run_rw", mem_readwriteN, (ph != 4) ? 1 : 0);
        if (i < n_instr) w = exp_ir[i];
        else             w = 16'h0000;
        case (ph)
          0:       checkOutput("fetch_addr", mem_address, i % 32);
          1:       checkOutput("loada_addr", mem_address, {w[13], w[12:9]});
          2, 3:    checkOutput("loadb_addr", mem_address, {w[13], w[8:5]});
          default: begin
            checkOutput("write_addr", mem_address, exp_wa[i]);
            checkOutput("write_data", mem_wdata, exp_wd[i]);
          end
        endcase
      end
    end
  end

  task automatic clear_ram();
    for (int a = 0; a < 32; a++) ram[a] = 16'h0000;
  endtask

  task automatic load_default();
    clear_ram();
    ram[0]  = 16'h2036;
    ram[1]  = 16'h6057;
    ram[2]  = 16'hA698;
    ram[3]  = 16'h28B9;
    ram[4]  = 16'hC000;
    ram[16] = 16'h0304;
    ram[17] = 16'h0709;
    ram[18] = 16'h0D0E;
    ram[19] = 16'h0200;
    ram[20] = 16'hFFFA;
    ram[21] = 16'h0000;
  endtask

  // Pulse start for one edge and let the compare process follow `cycles` edges.
  task automatic applyStimulus(input int cap, input int cycles);
    model_run(cap);
    @(negedge clk);
    start  = 1'b1;
    active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (cycles - 1) @(negedge clk);
    active = 1'b0;
  endtask

  task automatic check_memory(input string tag);
    for (int a = 0; a < 32; a++) checkOutput(tag, ram[a], model_mem[a]);
  endtask

  initial begin
    clear_ram();
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rw", mem_readwriteN, 1);
    checkOutput("reset_addr", mem_address, 0);
    checkOutput("reset_wdata", mem_wdata, 0);
    checkOutput("reset_pc", pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] default program");
    load_default();
    applyStimulus(40, 24);
    check_memory("default_mem");
    checkOutput("default_r22", ram[22], 16'h0A0D);
    checkOutput("default_r23", ram[23], 16'hF6F6);
    checkOutput("default_r24", ram[24], 16'hFEF4);
    checkOutput("default_r25", ram[25], 16'hFFFA);
    checkOutput("default_latency", first_done, 21);
    checkOutput("default_pc", pc, 4);
    checkOutput("default_done", done, 1);

    $display("[TB] restart from halt");
    applyStimulus(40, 24);
    check_memory("restart_mem");
    checkOutput("restart_r22", ram[22], 16'h0A0D);
    checkOutput("restart_r25", ram[25], 16'hFFFA);
    checkOutput("restart_latency", first_done, 21);

    $display("[TB] overflow wrap");
    clear_ram();
    ram[0]  = 16'h2038;
    ram[1]  = 16'hA479;
    ram[2]  = 16'hC000;
    ram[16] = 16'h7F00;
    ram[17] = 16'h0100;
    ram[18] = 16'h6400;
    ram[19] = 16'h0200;
    applyStimulus(40, 14);
    check_memory("ovf_mem");
    checkOutput("ovf_add", ram[24], 16'h8000);
    checkOutput("ovf_mul", ram[25], 16'hC800);
    checkOutput("ovf_latency", first_done, 11);

    $display("[TB] halt at address 0");
    clear_ram();
    ram[0] = 16'hC000;
    applyStimulus(40, 5);
    check_memory("halt0_mem");
    checkOutput("halt0_latency", first_done, 1);
    checkOutput("halt0_pc", pc, 0);

    $display("[TB] reset during LOAD_B");
    load_default();
    ram[22] = 16'h1234;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    checkOutput("loadb_busy", busy, 1);
    checkOutput("loadb_addr_pre", mem_address, 17);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_rw", mem_readwriteN, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_addr", mem_address, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_dest_kept", ram[22], 16'h1234);
    rst_n = 1'b1;
    applyStimulus(40, 24);
    check_memory("after_rst_mem");
    checkOutput("after_rst_r22", ram[22], 16'h0A0D);
    checkOutput("after_rst_latency", first_done, 21);

    $display("[TB] no halt, pc wrap");
    for (int a = 0; a < 32; a++) ram[a] = 16'h225F;
    applyStimulus(34, 170);
    check_memory("wrap_mem");
    checkOutput("wrap_done", done, 0);
    checkOutput("wrap_busy", busy, 1);
    checkOutput("wrap_pc", pc, 1);
    checkOutput("wrap_first_done", first_done, -1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
